// File: rtl/matrix_index_sequencer.sv
// Three chained up/down index counters walking every (slice, row, col) of a ROWS x COLS x DEPTH matrix.
// Optional macro CONTINUOUS_SCAN_EN: adds a stop input and wraps to the start position instead of finishing.
module matrix_index_sequencer #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int DEPTH = 64,
  parameter int RW    = 3,
  parameter int CW    = 3,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          select,
  input  logic          en,
`ifdef CONTINUOUS_SCAN_EN
  input  logic          stop,
`endif
  input  logic          ld,
  input  logic [RW-1:0] ld_row,
  input  logic [CW-1:0] ld_col,
  input  logic [DW-1:0] ld_depth,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic          valid,
  output logic          last,
  output logic          co,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [DW-1:0] DEP_MAX = DW'(DEPTH - 1);

  function automatic logic [RW-1:0] sat_row(input logic [RW-1:0] v);
    return (v > ROW_MAX) ? ROW_MAX : v;
  endfunction

  function automatic logic [CW-1:0] sat_col(input logic [CW-1:0] v);
    return (v > COL_MAX) ? COL_MAX : v;
  endfunction

  function automatic logic [DW-1:0] sat_dep(input logic [DW-1:0] v);
    return (v > DEP_MAX) ? DEP_MAX : v;
  endfunction

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [RW-1:0] row_q, row_d, row_step;
  logic [CW-1:0] col_q, col_d, col_step;
  logic [DW-1:0] dep_q, dep_d, dep_step;
  logic          col_end, row_end, last_pos;
`ifdef CONTINUOUS_SCAN_EN
  logic          wrap_hit, wrap_done_q;
`endif

  // Boundary detection and the single-step successor for the latched direction
  always_comb begin
    col_end  = dir_q ? (col_q == COL_MAX) : (col_q == '0);
    row_end  = dir_q ? (row_q == ROW_MAX) : (row_q == '0);
    last_pos = dir_q ? (col_q == COL_MAX && row_q == ROW_MAX && dep_q == DEP_MAX)
                     : (col_q == '0 && row_q == '0 && dep_q == '0);
    col_step = col_end ? (dir_q ? '0 : COL_MAX) : (dir_q ? col_q + CW'(1) : col_q - CW'(1));
    row_step = row_q;
    dep_step = dep_q;
    if (col_end) begin
      row_step = row_end ? (dir_q ? '0 : ROW_MAX) : (dir_q ? row_q + RW'(1) : row_q - RW'(1));
      if (row_end)
        dep_step = dir_q ? dep_q + DW'(1) : dep_q - DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    dep_d   = dep_q;
`ifdef CONTINUOUS_SCAN_EN
    wrap_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dir_d   = select;
          row_d   = select ? '0 : ROW_MAX;
          col_d   = select ? '0 : COL_MAX;
          dep_d   = select ? '0 : DEP_MAX;
        end
      end
      RUN: begin
        if (ld) begin
          row_d = sat_row(ld_row);
          col_d = sat_col(ld_col);
          dep_d = sat_dep(ld_depth);
        end else if (en) begin
          if (last_pos) begin
`ifdef CONTINUOUS_SCAN_EN
            wrap_hit = 1'b1;
            row_d    = dir_q ? '0 : ROW_MAX;
            col_d    = dir_q ? '0 : COL_MAX;
            dep_d    = dir_q ? '0 : DEP_MAX;
`else
            state_d = DONE;
`endif
          end else begin
            row_d = row_step;
            col_d = col_step;
            dep_d = dep_step;
          end
        end
`ifdef CONTINUOUS_SCAN_EN
        else if (stop) begin
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b1;
      row_q <= '0;
      col_q <= '0;
      dep_q <= '0;
    end else begin
      dir_q <= dir_d;
      row_q <= row_d;
      col_q <= col_d;
      dep_q <= dep_d;
    end
  end

`ifdef CONTINUOUS_SCAN_EN
  always_ff @(posedge clk) begin
    if (rst) wrap_done_q <= 1'b0;
    else     wrap_done_q <= wrap_hit;
  end
  assign done = (state_q == DONE) | wrap_done_q;
`else
  assign done = (state_q == DONE);
`endif

  assign row   = row_q;
  assign col   = col_q;
  assign depth = dep_q;
  assign busy  = (state_q != IDLE);
  assign valid = (state_q == RUN);
  assign last  = valid & last_pos;
  assign co    = last & en;

endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Random and directed bench for matrix_index_sequencer: default 5x5x64 and a 2x3x2 geometry
// checked every cycle against a linear-position reference model.
module tb_matrix_index_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, select, en, ld;
  logic [2:0] ld_row0, ld_col0;
  logic [5:0] ld_depth0;
  logic [0:0] ld_row1, ld_depth1;
  logic [1:0] ld_col1;

  logic [2:0] row0, col0;
  logic [5:0] depth0;
  logic busy0, valid0, last0, co0, done0;
  logic [0:0] row1, depth1;
  logic [1:0] col1;
  logic busy1, valid1, last1, co1, done1;

  matrix_index_sequencer u0 (
    .clk(clk), .rst(rst), .start(start), .select(select), .en(en),
`ifdef CONTINUOUS_SCAN_EN
    .stop(1'b0),
`endif
    .ld(ld), .ld_row(ld_row0), .ld_col(ld_col0), .ld_depth(ld_depth0),
    .row(row0), .col(col0), .depth(depth0),
    .busy(busy0), .valid(valid0), .last(last0), .co(co0), .done(done0)
  );

  matrix_index_sequencer #(.ROWS(2), .COLS(3), .DEPTH(2), .RW(1), .CW(2), .DW(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .select(select), .en(en),
`ifdef CONTINUOUS_SCAN_EN
    .stop(1'b0),
`endif
    .ld(ld), .ld_row(ld_row1), .ld_col(ld_col1), .ld_depth(ld_depth1),
    .row(row1), .col(col1), .depth(depth1),
    .busy(busy1), .valid(valid1), .last(last1), .co(co1), .done(done1)
  );

  // Model: 0 idle, 1 run, 2 done; position is a linear index into the traversal order
  typedef struct {
    int st;
    int pos;
    bit dir;
  } mdl_t;

  mdl_t m0, m1;
  int n_checks = 0;
  int n_errors = 0;
  int run_cnt, done_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_last(input mdl_t m, input int n);
    return (m.st == 1) && (m.pos == (m.dir ? n - 1 : 0));
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit s, input bit sel,
                                 input bit e, input bit l, input int lr, input int lc,
                                 input int ldd, input int R, input int C, input int D);
    mdl_t n = m;
    int total = R * C * D;
    if (r) begin
      n.st = 0; n.pos = 0; n.dir = 1'b1;
      return n;
    end
    case (m.st)
      0: if (s) begin
        n.st = 1; n.dir = sel; n.pos = sel ? 0 : total - 1;
      end
      1: begin
        if (l)
          n.pos = imin(ldd, D - 1) * R * C + imin(lr, R - 1) * C + imin(lc, C - 1);
        else if (e) begin
          if (m_last(m, total)) n.st = 2;
          else n.pos = m.dir ? m.pos + 1 : m.pos - 1;
        end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  task automatic check_dut(input string p, input mdl_t m, input int R, input int C, input int D,
                           input int r, input int c, input int d, input bit b, input bit v,
                           input bit la, input bit cy, input bit dn, input bit e);
    bit el = m_last(m, R * C * D);
    check({p, ".row"},   r,  (m.pos / C) % R);
    check({p, ".col"},   c,  m.pos % C);
    check({p, ".depth"}, d,  m.pos / (R * C));
    check({p, ".busy"},  b,  m.st != 0);
    check({p, ".valid"}, v,  m.st == 1);
    check({p, ".last"},  la, el);
    check({p, ".co"},    cy, el && e);
    check({p, ".done"},  dn, m.st == 2);
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut("u0", m0, 5, 5, 64, row0, col0, depth0, busy0, valid0, last0, co0, done0, en);
    check_dut("u1", m1, 2, 3, 2, row1, col1, depth1, busy1, valid1, last1, co1, done1, en);
    if (valid0) run_cnt++;
    if (done0)  done_cnt++;
    @(posedge clk);
    m0 = mstep(m0, rst, start, select, en, ld, ld_row0, ld_col0, ld_depth0, 5, 5, 64);
    m1 = mstep(m1, rst, start, select, en, ld, ld_row1, ld_col1, ld_depth1, 2, 3, 2);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; select = 1'b0; en = 1'b0; ld = 1'b0;
    ld_row0 = '0; ld_col0 = '0; ld_depth0 = '0;
    ld_row1 = '0; ld_col1 = '0; ld_depth1 = '0;
    m0 = '{st: 0, pos: 0, dir: 1'b1};
    m1 = m0;
    run_cnt = 0; done_cnt = 0;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Full ascending traversal with en held
    start = 1'b1; select = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    run_cnt = 0; done_cnt = 0;
    repeat (1602) tick();
    check("u0.run_cycles", run_cnt, 1600);
    check("u0.done_pulses", done_cnt, 1);

    // Descending traversal (u1 covers all 12 positions)
    start = 1'b1; select = 1'b0;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Stall pattern then load with saturation, ld winning over en
    start = 1'b1; select = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    en = 1'b1; tick();
    en = 1'b0; tick(); tick();
    en = 1'b1; tick();
    ld = 1'b1; ld_row0 = 3'd2; ld_col0 = 3'd7; ld_depth0 = 6'd5;
    ld_row1 = 1'b1; ld_col1 = 2'd3; ld_depth1 = 1'b1;
    tick();
    ld = 1'b0;
    check("u0.ld_depth", depth0, 5);
    check("u0.ld_row", row0, 2);
    check("u0.ld_col", col0, 4);
    tick();
    check("u0.after_ld_row", row0, 3);
    check("u0.after_ld_col", col0, 0);

    // start during RUN is ignored; reset mid-traversal aborts without done
    start = 1'b1; tick(); tick();
    start = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; tick(); tick();

    // Randomized traffic
    repeat (3000) begin
      rst       = ($urandom_range(0, 63) == 0);
      start     = ($urandom_range(0, 7) == 0);
      select    = $urandom_range(0, 1);
      en        = ($urandom_range(0, 3) != 0);
      ld        = ($urandom_range(0, 15) == 0);
      ld_row0   = 3'($urandom);
      ld_col0   = 3'($urandom);
      ld_depth0 = 6'($urandom);
      ld_row1   = 1'($urandom);
      ld_col1   = 2'($urandom);
      ld_depth1 = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
